// File: rtl/exec_sequencer.sv
// One-instruction-at-a-time sequencer for the shared ALU and the 2R/1W register file.
// Walks IDLE -> READ -> EXEC -> WRITE and owns the register file write port.
module exec_sequencer #(
  parameter int          WIDTH   = 32,
  parameter logic [2:0]  ALU_ADD = 3'd0,
  parameter logic [2:0]  ALU_SUB = 3'd1,
  parameter logic [2:0]  ALU_SLT = 3'd2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [11:0]      imm12,
  output logic [4:0]       rf_read1_location,
  output logic [4:0]       rf_read2_location,
  input  logic [WIDTH-1:0] rf_read1_out,
  input  logic [WIDTH-1:0] rf_read2_out,
  output logic [4:0]       rf_write_location,
  output logic [WIDTH-1:0] rf_write_data,
  output logic             rf_write_enabled,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_out,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_data,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WRITE = 2'd3} state_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm12;
  } instr_t;

  state_t           state, state_nx;
  instr_t           instr_q;
  logic [WIDTH-1:0] opnd_x, opnd_y, res_q;
  logic             accept, legal, itype;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == 7'd1) || (op == 7'd2) || (op == 7'd3) ||
           (op == 7'd11) || (op == 7'd12) || (op == 7'd13);
  endfunction

  assign accept = instr_valid && instr_ready;
  assign legal  = is_legal(opcode);
  assign itype  = (instr_q.opcode >= 7'd11);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept && legal) state_nx = READ;
      READ:  state_nx = EXEC;
      EXEC:  state_nx = WRITE;
      WRITE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // result_data is loaded alongside res_q so it already shows the new value
  // while result_valid is high, and then holds until the next retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q     <= '0;
      opnd_x      <= '0;
      opnd_y      <= '0;
      res_q       <= '0;
      result_data <= '0;
      illegal     <= 1'b0;
    end else begin
      illegal <= accept && !legal;
      if (accept) instr_q <= '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2, imm12: imm12};
      if (state == READ) begin
        opnd_x <= rf_read1_out;
        opnd_y <= itype ? {{(WIDTH-12){1'b0}}, instr_q.imm12} : rf_read2_out;
      end
      if (state == EXEC) begin
        res_q       <= alu_out;
        result_data <= alu_out;
      end
    end
  end

  always_comb begin
    instr_ready       = (state == IDLE);
    rf_read1_location = instr_q.rs1;
    rf_read2_location = instr_q.rs2;
    rf_write_location = instr_q.rd;
    rf_write_data     = res_q;
    alu_x             = opnd_x;
    alu_y             = opnd_y;
    // x0 writes are dropped; a reset landing on WRITE cancels the commit.
    rf_write_enabled  = (state == WRITE) && (instr_q.rd != 5'd0) && !reset;
    result_valid      = (state == WRITE) && !reset;
    alu_op            = ALU_ADD;
    case (instr_q.opcode)
      7'd2, 7'd12: alu_op = ALU_SUB;
      7'd3, 7'd13: alu_op = ALU_SLT;
      default:     alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: behavioural register file and ALU around the DUT,
// expected retirements queued at issue and compared on result_valid.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm12;
  logic [4:0]  rf_read1_location, rf_read2_location, rf_write_location;
  logic [31:0] rf_read1_out, rf_read2_out, rf_write_data;
  logic        rf_write_enabled;
  logic [2:0]  alu_op;
  logic [31:0] alu_x, alu_y, alu_out;
  logic        result_valid;
  logic [31:0] result_data;
  logic        illegal;

  exec_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm12(imm12),
    .rf_read1_location(rf_read1_location), .rf_read2_location(rf_read2_location),
    .rf_read1_out(rf_read1_out), .rf_read2_out(rf_read2_out),
    .rf_write_location(rf_write_location), .rf_write_data(rf_write_data),
    .rf_write_enabled(rf_write_enabled), .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .result_valid(result_valid), .result_data(result_data),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [31:0] regs [32];
  logic [31:0] sh   [32];

  assign rf_read1_out = regs[rf_read1_location];
  assign rf_read2_out = regs[rf_read2_location];

  always @(posedge clk)
    if (rf_write_enabled && rf_write_location != 5'd0) regs[rf_write_location] <= rf_write_data;

  always_comb begin
    alu_out = 32'h0;
    case (alu_op)
      3'd0: alu_out = alu_x + alu_y;
      3'd1: alu_out = alu_x - alu_y;
      3'd2: alu_out = ($signed(alu_x) < $signed(alu_y)) ? 32'd1 : 32'd0;
      default: alu_out = 32'h0;
    endcase
  end

  typedef struct { logic [4:0] rd; logic [31:0] data; } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [6:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      7'd1, 7'd11: return a + b;
      7'd2, 7'd12: return a - b;
      default:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic setreg(input int idx, input logic [31:0] v);
    regs[idx] = v;
    sh[idx]   = v;
  endtask

  // Handshake one instruction; on return the DUT is one cycle past the accept edge.
  task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [11:0] imm);
    exp_t e;
    int   w;
    logic [31:0] b;
    b = (op >= 7'd11) ? {20'h0, imm} : sh[s2];
    e.rd   = d;
    e.data = model(op, sh[s1], b);
    sb.push_back(e);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; imm12 = imm;
    instr_valid = 1'b1;
    w = 0;
    while (!instr_ready && w < 10) begin tick(); w++; end
    if (w == 10) chk("ready_timeout", 32'd0, 32'd1);
    tick();
    instr_valid = 1'b0;
    opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
    rs2 = 5'($urandom); imm12 = 12'($urandom);
  endtask

  // Wait in READ/EXEC for result_valid, then compare the WRITE cycle against the queue.
  task automatic retire(input string tag);
    exp_t e;
    int   c;
    c = 1;
    while (!result_valid && c < 8) begin
      chk({tag, "_busy_ready"}, 32'(instr_ready), 32'd0);
      tick();
      c++;
    end
    chk({tag, "_latency"}, 32'(c), 32'd3);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_we"},    32'(rf_write_enabled), (e.rd != 5'd0) ? 32'd1 : 32'd0);
    chk({tag, "_wloc"},  32'(rf_write_location), 32'(e.rd));
    chk({tag, "_wdata"}, rf_write_data, e.data);
    chk({tag, "_rdata"}, result_data, e.data);
    if (e.rd != 5'd0) sh[e.rd] = e.data;
    tick();
    chk({tag, "_idle_ready"}, 32'(instr_ready), 32'd1);
    chk({tag, "_idle_we"},    32'(rf_write_enabled), 32'd0);
    chk({tag, "_rv_pulse"},   32'(result_valid), 32'd0);
    chk({tag, "_held"},       result_data, e.data);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) setreg(i, 32'h0);
    reset = 1'b1; instr_valid = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; imm12 = '0;
    tick(); tick();
    chk("rst_ready",  32'(instr_ready), 32'd1);
    chk("rst_rv",     32'(result_valid), 32'd0);
    chk("rst_we",     32'(rf_write_enabled), 32'd0);
    chk("rst_ill",    32'(illegal), 32'd0);
    chk("rst_rdata",  result_data, 32'd0);
    chk("rst_aluop",  32'(alu_op), 32'd0);
    reset = 1'b0;
    tick();

    setreg(1, 32'd5); setreg(2, 32'd7);
    send(7'd1, 5'd3, 5'd1, 5'd2, 12'h0);
    retire("add");

    setreg(1, 32'hFFFF_FFFF);
    send(7'd11, 5'd4, 5'd1, 5'd0, 12'hFFF);
    retire("addi");

    setreg(1, 32'd10); setreg(2, 32'd3);
    send(7'd2, 5'd5, 5'd1, 5'd2, 12'h0);
    retire("sub");
    send(7'd13, 5'd6, 5'd5, 5'd0, 12'h008);
    retire("slti");

    send(7'd1, 5'd0, 5'd1, 5'd2, 12'h0);
    retire("x0");

    setreg(7, 32'hFFFF_FFFF);
    send(7'd3, 5'd8, 5'd7, 5'd2, 12'h0);
    retire("slt_neg");
    send(7'd12, 5'd9, 5'd2, 5'd0, 12'h005);
    retire("subi");

    opcode = 7'h7F; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_ready", 32'(instr_ready), 32'd1);
    chk("ill_we",    32'(rf_write_enabled), 32'd0);
    tick();
    chk("ill_once",  32'(illegal), 32'd0);
    chk("ill_rv",    32'(result_valid), 32'd0);

    send(7'd1, 5'd3, 5'd1, 5'd2, 12'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    void'(sb.pop_front());
    chk("rstx_ready", 32'(instr_ready), 32'd1);
    chk("rstx_rdata", result_data, 32'd0);
    tick(); tick(); tick();
    chk("rstx_x3",    regs[3], sh[3]);
    chk("rstx_rv",    32'(result_valid), 32'd0);

    send(7'd1, 5'd3, 5'd1, 5'd2, 12'h0);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rstw_we", 32'(rf_write_enabled), 32'd0);
    tick();
    reset = 1'b0;
    void'(sb.pop_front());
    chk("rstw_x3", regs[3], sh[3]);

    send(7'd1, 5'd10, 5'd1, 5'd2, 12'h0);
    retire("recover");
    tick();

    chk("rf_x3",  regs[3],  32'd12);
    chk("rf_x4",  regs[4],  32'h0000_0FFE);
    chk("rf_x5",  regs[5],  32'd7);
    chk("rf_x6",  regs[6],  32'd1);
    chk("rf_x0",  regs[0],  32'd0);
    chk("rf_x8",  regs[8],  32'd1);
    chk("rf_x9",  regs[9],  32'hFFFF_FFFE);
    chk("rf_x10", regs[10], 32'd13);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle controller that sequences the shared ALU and the 2-read/1-write register file for one instruction at a time. Instructions arrive over a valid/ready handshake. The block drives register read addresses, selects ALU operands and op, and commits the ALU result to rd. It replaces ad-hoc state logic at the core top level and is the single owner of the register file write port.

Parameters:
WIDTH, 32, datapath width in bits
ALU_ADD, 0, alu_op encoding for add
ALU_SUB, 1, alu_op encoding for subtract
ALU_SLT, 2, alu_op encoding for less-than

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
instr_valid  input  1  instruction present on opcode/rd/rs1/rs2/imm12
instr_ready  output  1  sequencer can accept an instruction
opcode  input  7  1=ADD 2=SUB 3=SLT 11=ADDI 12=SUBI 13=SLTI
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2 (R-type only)
imm12  input  12  immediate (I-type only)
rf_read1_location  output  5  register file read port 1 address
rf_read2_location  output  5  register file read port 2 address
rf_read1_out  input  WIDTH  read port 1 data (combinational read)
rf_read2_out  input  WIDTH  read port 2 data (combinational read)
rf_write_location  output  5  write address
rf_write_data  output  WIDTH  write data
rf_write_enabled  output  1  write strobe, sampled by register file on clk
alu_op  output  3  ALU operation
alu_x  output  WIDTH  ALU operand x
alu_y  output  WIDTH  ALU operand y
alu_out  input  WIDTH  ALU result (combinational)
result_valid  output  1  one-cycle pulse: instruction retired
result_data  output  WIDTH  last retired result, held until next retire
illegal  output  1  one-cycle pulse: unknown opcode dropped

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state=IDLE; instr_ready=1.
  - rf_write_enabled=0; result_valid=0; illegal=0; result_data=0; alu_op=ALU_ADD.
  - Operand, latch and address registers cleared to 0.
- States: IDLE -> READ -> EXEC -> WRITE -> IDLE. 2-bit encoding: IDLE=0, READ=1, EXEC=2, WRITE=3.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch opcode, rd, rs1, rs2, imm12.
  - Legal opcode: go to READ.
  - Illegal opcode: pulse illegal on the next cycle, stay IDLE, no register write.
- READ:
  - instr_ready=0.
  - rf_read1_location=rs1_q; rf_read2_location=rs2_q.
  - At the clock edge, capture opnd_x=rf_read1_out.
  - opnd_y is captured as rf_read2_out for R-type, or zero-extended imm12 ({WIDTH-12 zeros, imm12}) for I-type.
  - Next state is EXEC.
- EXEC:
  - alu_x=opnd_x; alu_y=opnd_y.
  - alu_op from opcode: 1/11 -> ALU_ADD, 2/12 -> ALU_SUB, 3/13 -> ALU_SLT.
  - Capture res_q=alu_out. Next state is WRITE.
- WRITE:
  - rf_write_location=rd_q; rf_write_data=res_q.
  - rf_write_enabled=1 for exactly this cycle, except when rd_q==0 (x0 writes suppressed).
  - result_valid=1 and result_data<=res_q, asserted even when rd_q==0. Next state is IDLE.
- Timing:
  - Latency: handshake edge to result_valid high is 3 cycles.
  - Throughput: one instruction per 4 cycles.
  - No instruction is accepted in READ, EXEC or WRITE.
- Outputs outside their state:
  - rf_write_enabled=0 outside WRITE.
  - Address and ALU outputs hold their last values; not guaranteed meaningful outside their state.
- Hazards:
  - rs1/rs2 equal to a just-written rd reads the committed value. The write completes in WRITE before the next READ, so no forwarding is needed.
- Reset mid-operation: the instruction is abandoned and no write is issued, including reset asserted during WRITE (write is gated by !reset).
- Input stability: opcode/rd/rs*/imm12 are sampled only at the handshake edge; later changes are ignored.

Test Plan:
- R-type add: x1=5, x2=7 preloaded; issue ADD rd=3 rs1=1 rs2=2 -> 3 cycles later result_valid=1, rf_write_enabled=1, location=3, data=12; instr_ready=0 for 3 cycles.
- Immediate add: x1=0xFFFFFFFF; ADDI rd=4 rs1=1 imm12=0xFFF -> zero-extension gives x4=0x00000FFE.
- SUB then dependent SLTI back-to-back: SUB rd=5 (x1=10, x2=3) then SLTI rd=6 rs1=5 imm12=8 -> x5=7, then x6=1; second instruction accepted on the cycle after WRITE.
- x0 destination: ADD rd=0 -> result_valid pulses with result_data=sum; rf_write_enabled stays 0.
- Illegal opcode 0x7F with instr_valid=1 -> illegal pulses 1 cycle, no write, instr_ready stays 1.
- Reset asserted in EXEC of ADD rd=3 -> no write to x3; next cycle state IDLE, instr_ready=1, result_data=0.
